// File: rtl/l2_unmap_pkg.sv
// Shared constants and the level-1 lane map table for the L2 result demapper.
package l2_unmap_pkg;

  localparam int K  = 4;        // L1 lane count (lane maps below assume 4)
  localparam int W  = 16;       // lane width in bits
  localparam int NL = 2 * K;    // L2 lane count

  // IPV codes with distinct lane maps; codes 8..15 map nothing.
  localparam logic [3:0] IPV_DIRECT   = 4'd0;  // also 2
  localparam logic [3:0] IPV_SPLIT    = 4'd1;  // also 3
  localparam logic [3:0] IPV_ROT_A    = 4'd4;  // also 5
  localparam logic [3:0] IPV_ROT_B    = 4'd6;
  localparam logic [3:0] IPV_UPPER    = 4'd7;
  localparam logic [3:0] IPV_LAST_MAP = 4'd7;

  typedef logic [2:0] lane_idx_t;

  // live: the code maps lanes at all; sel[i]: L2 lane feeding result lane i;
  // used[j]: L2 lane j feeds some result lane.
  typedef struct packed {
    logic                  live;
    lane_idx_t [K-1:0]     sel;
    logic      [NL-1:0]    used;
  } lane_map_t;

  function automatic lane_map_t make_map(input lane_idx_t s0, input lane_idx_t s1,
                                         input lane_idx_t s2, input lane_idx_t s3);
    lane_map_t m;
    m.live   = 1'b1;
    m.sel    = {s3, s2, s1, s0};
    m.used   = '0;
    m.used[s0] = 1'b1;
    m.used[s1] = 1'b1;
    m.used[s2] = 1'b1;
    m.used[s3] = 1'b1;
    return m;
  endfunction

  function automatic lane_map_t lane_map(input logic [3:0] ipv);
    lane_map_t m;
    m = '0;
    case (ipv)
      4'd0, 4'd2: m = make_map(3'd0, 3'd1, 3'd2, 3'd3);
      4'd1, 4'd3: m = make_map(3'd0, 3'd1, 3'd4, 3'd5);
      4'd4, 4'd5: m = make_map(3'd4, 3'd0, 3'd1, 3'd5);
      4'd6:       m = make_map(3'd4, 3'd5, 3'd0, 3'd1);
      4'd7:       m = make_map(3'd4, 3'd5, 3'd6, 3'd7);
      default:    m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/l2_unmap_fifo2.sv
// Two-entry valid/ready FIFO holding gathered beats with their IPV.
// Writes are refused while rst is high so no handshake completes in reset.
module l2_unmap_fifo2 #(
  parameter int DATA_W = 68
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              push, pop;

  assign wr_ready_o = !rst && (cnt_q != 2'd2);
  assign rd_valid_o = (cnt_q != 2'd0);
  assign rd_data_o  = mem_q[rd_ptr_q];
  assign push       = wr_valid_i && wr_ready_o;
  assign pop        = rd_valid_o && rd_ready_i && !rst;

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state; reset empties the FIFO and discards buffered beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage; only written on an accepted beat, never reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/l2_result_unmap.sv
// Return-path demapper: gathers the L2 lanes selected by the active IPV back
// into L1 lane order, buffers two beats and counts delivered beats.
// Optional unused-lane checker enabled by defining L2_RESULT_UNMAP_CHECK_EN.
module l2_result_unmap
  import l2_unmap_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [3:0]        IPV_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*K*W-1:0]  L2_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [K*W-1:0]    L1_res,
  output logic [3:0]        IPV_out,
  output logic [15:0]       beat_cnt,
  output logic              err
);

  localparam int ENTRY_W = 4 + K * W;

  logic [3:0]         ipv_r_q;
  logic [3:0]         ipv_eff;
  lane_map_t          map;
  logic [W-1:0]       l2_lane [NL];
  logic [K*W-1:0]     gathered;
  logic [ENTRY_W-1:0] head;
  logic               accept;
  logic [15:0]        beat_cnt_q;

  // The IPV seen by a beat is the one presented in its own accept cycle.
  assign ipv_eff = en ? IPV_in : ipv_r_q;
  assign map     = lane_map(ipv_eff);
  assign accept  = in_valid && in_ready;

  // Hold the last effective IPV so beats keep mapping after en drops.
  always_ff @(posedge clk) begin
    if (rst) ipv_r_q <= 4'd0;
    else     ipv_r_q <= ipv_eff;
  end

  // Split the L2 bus into lanes (lane 0 in the top bits) and gather.
  always_comb begin
    for (int j = 0; j < NL; j++) begin
      l2_lane[j] = L2_out[2*K*W-1-W*j -: W];
    end
    gathered = '0;
    if (map.live) begin
      for (int i = 0; i < K; i++) begin
        gathered[K*W-1-W*i -: W] = l2_lane[map.sel[i]];
      end
    end
  end

  l2_unmap_fifo2 #(
    .DATA_W (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_valid_i (in_valid),
    .wr_ready_o (in_ready),
    .wr_data_i  ({ipv_eff, gathered}),
    .rd_valid_o (out_valid),
    .rd_ready_i (out_ready),
    .rd_data_o  (head)
  );

  // Outputs read zero whenever nothing is buffered.
  assign L1_res  = out_valid ? head[K*W-1:0]       : '0;
  assign IPV_out = out_valid ? head[ENTRY_W-1 -: 4] : 4'd0;

  // Delivered-beat counter, free-running wrap at 16 bits.
  always_ff @(posedge clk) begin
    if (rst)                         beat_cnt_q <= 16'd0;
    else if (out_valid && out_ready) beat_cnt_q <= beat_cnt_q + 16'd1;
  end
  assign beat_cnt = beat_cnt_q;

`ifdef L2_RESULT_UNMAP_CHECK_EN
  logic [NL-1:0] lane_nz;
  logic          stray;
  logic          err_q;

  always_comb begin
    for (int j = 0; j < NL; j++) begin
      lane_nz[j] = |l2_lane[j];
    end
    stray = |(lane_nz & ~map.used);
  end

  // Sticky flag: any nonzero lane outside the map on an accepted beat.
  always_ff @(posedge clk) begin
    if (rst)                 err_q <= 1'b0;
    else if (accept && stray) err_q <= 1'b1;
  end
  assign err = err_q;
`else
  logic unused_chk;
  assign unused_chk = ^{map.used, accept};
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_l2_result_unmap.sv
`timescale 1ns/1ps
module tb_l2_result_unmap;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [3:0]   IPV_in;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] L2_out;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  L1_res;
  logic [3:0]   IPV_out;
  logic [15:0]  beat_cnt;
  logic         err;

  int checks   = 0;
  int failures = 0;

`ifdef L2_RESULT_UNMAP_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  always #5 clk = ~clk;

  l2_result_unmap dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .IPV_in    (IPV_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .L2_out    (L2_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .L1_res    (L1_res),
    .IPV_out   (IPV_out),
    .beat_cnt  (beat_cnt),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Lane j (lane 0 in the top bits) = base + j.
  function automatic logic [127:0] pack8(input logic [15:0] base);
    logic [127:0] v;
    for (int j = 0; j < 8; j++) v[127-16*j -: 16] = base + 16'(j);
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; en = 1'b0; IPV_in = 4'd0; in_valid = 1'b0;
    out_ready = 1'b0; L2_out = '0;
    #1;
    chk("ready_in_reset_pre", in_ready, 0);
    tick;
    chk("ready_in_reset", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_l1_res", L1_res, 0);
    chk("rst_ipv_out", IPV_out, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", in_ready, 1);

    // Direct map, IPV 0.
    en = 1'b1; IPV_in = 4'd0; out_ready = 1'b1; in_valid = 1'b1;
    L2_out = {16'h1111, 16'h2222, 16'h3333, 16'h4444,
              16'h5555, 16'h6666, 16'h7777, 16'h8888};
    tick;
    in_valid = 1'b0;
    chk("ipv0_valid", out_valid, 1);
    chk("ipv0_res", L1_res, 64'h1111_2222_3333_4444);
    chk("ipv0_ipv", IPV_out, 0);
    tick;
    chk("ipv0_cnt", beat_cnt, 1);
    chk("ipv0_drained", out_valid, 0);

    // IPV 6 captured for one cycle, then held with en low.
    en = 1'b1; IPV_in = 4'd6; in_valid = 1'b1; L2_out = pack8(16'hA000);
    tick;
    en = 1'b0; IPV_in = 4'd0;
    chk("ipv6_res_a", L1_res, 64'hA004_A005_A000_A001);
    chk("ipv6_ipv_a", IPV_out, 6);
    tick;
    chk("ipv6_res_b", L1_res, 64'hA004_A005_A000_A001);
    chk("ipv6_ipv_b", IPV_out, 6);
    chk("ipv6_cnt_b", beat_cnt, 2);
    tick;
    in_valid = 1'b0;
    chk("ipv6_res_c", L1_res, 64'hA004_A005_A000_A001);
    chk("ipv6_cnt_c", beat_cnt, 3);
    tick;
    chk("ipv6_cnt_d", beat_cnt, 4);

    // Backpressure with IPV 4: two buffered, third refused.
    en = 1'b1; IPV_in = 4'd4; out_ready = 1'b0; in_valid = 1'b1;
    L2_out = pack8(16'hB000);
    tick;
    L2_out = pack8(16'hB010);
    tick;
    L2_out = pack8(16'hB020);
    chk("full_ready", in_ready, 0);
    tick;
    chk("full_ready_hold", in_ready, 0);
    chk("full_head", L1_res, 64'hB004_B000_B001_B005);
    chk("full_ipv", IPV_out, 4);
    chk("full_cnt", beat_cnt, 4);
    out_ready = 1'b1;
    tick;
    chk("bp_head1", L1_res, 64'hB014_B010_B011_B015);
    chk("bp_cnt1", beat_cnt, 5);
    tick;
    in_valid = 1'b0;
    chk("bp_head2", L1_res, 64'hB024_B020_B021_B025);
    chk("bp_cnt2", beat_cnt, 6);
    tick;
    chk("bp_cnt3", beat_cnt, 7);
    chk("bp_empty", out_valid, 0);

    // IPV 9 maps nothing.
    en = 1'b1; IPV_in = 4'd9; in_valid = 1'b1; L2_out = pack8(16'h1111);
    tick;
    in_valid = 1'b0;
    chk("ipv9_res", L1_res, 0);
    chk("ipv9_valid", out_valid, 1);
    chk("ipv9_ipv", IPV_out, 9);
    chk("ipv9_err", err, CHK);
    tick;
    chk("ipv9_err_sticky", err, CHK);

    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst2_err", err, 0);
    chk("rst2_cnt", beat_cnt, 0);

    // IPV 1: clean beat, then stray data on lane 2.
    en = 1'b1; IPV_in = 4'd1; out_ready = 1'b1; in_valid = 1'b1;
    L2_out = {16'hC000, 16'hC001, 16'h0000, 16'h0000,
              16'hC004, 16'hC005, 16'h0000, 16'h0000};
    tick;
    L2_out = {16'h0000, 16'h0000, 16'h0001, 16'h0000,
              16'h0000, 16'h0000, 16'h0000, 16'h0000};
    chk("ipv1_res", L1_res, 64'hC000_C001_C004_C005);
    chk("ipv1_clean_err", err, 0);
    tick;
    in_valid = 1'b0;
    chk("ipv1_stray_res", L1_res, 0);
    chk("ipv1_stray_err", err, CHK);
    tick;
    chk("ipv1_err_sticky", err, CHK);
    chk("ipv1_cnt", beat_cnt, 2);

    // Counter wrap.
    en = 1'b1; IPV_in = 4'd0; in_valid = 1'b1; out_ready = 1'b1;
    L2_out = pack8(16'h1000);
    n = 0;
    while (beat_cnt !== 16'hFFFF && n < 70000) begin
      tick;
      n++;
    end
    chk("wrap_ffff", beat_cnt, 16'hFFFF);
    tick;
    chk("wrap_zero", beat_cnt, 16'h0000);
    chk("wrap_res", L1_res, 64'h1000_1001_1002_1003);

    // Reset with two beats buffered.
    out_ready = 1'b0;
    tick;
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_ready", in_ready, 0);
    rst = 1'b1;
    tick;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_cnt", beat_cnt, 0);
    chk("mid_rst_res", L1_res, 0);
    chk("mid_rst_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
